// File: rtl/mesh_router_sync.sv
// mesh_router_sync: 5-port dimension-ordered mesh router node, per-input FIFOs, per-output RR arbiters
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data per input L,N,E,S,W (index 0..4);
//        out_valid/out_ready/out_data per output, packet p at [p*WIDTH +: WIDTH].
module mesh_router_sync #(
  parameter int WIDTH     = 33,
  parameter int DEPTH     = 4,
  parameter int X_HOP_LOC = 2,
  parameter int X_HOP_W   = 2,
  parameter int Y_HOP_LOC = 4,
  parameter int Y_HOP_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  input  logic [5*WIDTH-1:0] in_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready,
  output logic [5*WIDTH-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [5][DEPTH];
  logic [AW-1:0]    wp [5];
  logic [AW-1:0]    rp [5];
  logic [AW:0]      cnt [5];
  logic [WIDTH-1:0] head [5];
  logic [WIDTH-1:0] fwd [5];
  logic [WIDTH-1:0] od [5];
  logic [2:0]       dst [5];
  logic [2:0]       ptr [5];
  logic [2:0]       gi [5];
  logic [4:0]       full, empty, push, pop, ga, ld;
  genvar p;
  for (p = 0; p < 5; p++) begin : g_port
    assign full[p]     = cnt[p] == (AW+1)'(DEPTH);
    assign empty[p]    = cnt[p] == '0;
    assign in_ready[p] = rst_n & ~full[p];
    assign push[p]     = in_valid[p] & in_ready[p];
    assign head[p]     = mem[p][rp[p]];
    assign out_data[p*WIDTH +: WIDTH] = od[p];
  end
  // X first, then Y; the forwarded copy carries the decremented hop count
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      fwd[i] = head[i];
      dst[i] = 3'd0;
      if (head[i][X_HOP_LOC +: X_HOP_W] != '0) begin
        fwd[i][X_HOP_LOC +: X_HOP_W] = head[i][X_HOP_LOC +: X_HOP_W] - 1'b1;
        dst[i] = head[i][0] ? 3'd2 : 3'd4;
      end else if (head[i][Y_HOP_LOC +: Y_HOP_W] != '0) begin
        fwd[i][Y_HOP_LOC +: Y_HOP_W] = head[i][Y_HOP_LOC +: Y_HOP_W] - 1'b1;
        dst[i] = head[i][1] ? 3'd3 : 3'd1;
      end
    end
  end
  // cyclic search from ptr[o]; a grant only takes effect when the output can load
  always_comb begin
    int j;
    j   = 0;
    pop = '0;
    for (int o = 0; o < 5; o++) begin
      ga[o] = 1'b0;
      gi[o] = 3'd0;
      for (int k = 0; k < 5; k++) begin
        j = (int'(ptr[o]) + k) % 5;
        if (!ga[o] && !empty[j] && dst[j] == 3'(o)) begin
          ga[o] = 1'b1;
          gi[o] = 3'(j);
        end
      end
      ld[o] = ga[o] & (~out_valid[o] | out_ready[o]);
      if (ld[o]) pop[gi[o]] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (push[i]) mem[i][wp[i]] <= in_data[i*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      for (int i = 0; i < 5; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
        ptr[i] <= '0;
        od[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (pop[i]) rp[i] <= rp[i] + 1'b1;
        cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        if (ld[i]) begin
          out_valid[i] <= 1'b1;
          od[i]        <= fwd[gi[i]];
          ptr[i]       <= gi[i] == 3'd4 ? 3'd0 : gi[i] + 3'd1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mesh_router_sync.sv
// tb_mesh_router_sync: directed self-checking bench for mesh_router_sync
module tb_mesh_router_sync;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   in_valid = '0;
  logic [4:0]   in_ready;
  logic [164:0] in_data = '0;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready = 5'b11111;
  logic [164:0] out_data;
  int checks = 0;
  int failures = 0;

  mesh_router_sync dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] od(input int p);
    return out_data[p*33 +: 33];
  endfunction

  task automatic put(input int p, input logic [32:0] d, input logic v);
    in_data[p*33 +: 33] = d;
    in_valid[p] = v;
  endtask

  task automatic do_reset;
    in_valid = '0;
    out_ready = 5'b11111;
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask

  task automatic hop(input string tag, input int ip, input logic [32:0] din, input int op, input logic [32:0] dout);
    put(ip, din, 1'b1);
    tick;
    put(ip, '0, 1'b0);
    tick;
    chk({tag, "_valid"}, out_valid, 64'(5'b1 << op));
    chk({tag, "_data"}, od(op), dout);
    tick;
  endtask

  logic [32:0] exp_q [$];
  int sent [3];
  int src [3] = '{1, 3, 4};
  int n;
  logic [4:0] acc;

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 5'b00000);
    chk("rst_out_valid", out_valid, 5'b00000);
    chk("rst_out_data", out_data, '0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", in_ready, 5'b11111);
    chk("post_rst_out_valid", out_valid, 5'b00000);

    put(4, 33'h5, 1'b1);
    tick;
    put(4, '0, 1'b0);
    chk("single_latency", out_valid, 5'b00000);
    tick;
    chk("single_valid", out_valid, 5'b00100);
    chk("single_data", od(2), 33'h1);
    tick;
    chk("single_clear", out_valid, 5'b00000);

    hop("xy_l2e", 0, 33'h1_2345_671B, 2, 33'h1_2345_6717);
    hop("xy_w2e", 4, 33'h1_2345_6717, 2, 33'h1_2345_6713);
    hop("xy_w2s", 4, 33'h1_2345_6713, 3, 33'h1_2345_6703);
    hop("xy_n2l", 1, 33'h1_2345_6703, 0, 33'h1_2345_6703);

    do_reset;
    for (int k = 0; k < 6; k++)
      for (int s = 0; s < 3; s++) exp_q.push_back(33'((src[s] << 12) | (k << 8)));
    sent = '{0, 0, 0};
    n = 0;
    for (int c = 0; c < 60; c++) begin
      for (int s = 0; s < 3; s++)
        put(src[s], 33'((src[s] << 12) | (sent[s] << 8)), sent[s] < 6);
      acc = in_valid & in_ready;
      tick;
      for (int s = 0; s < 3; s++) if (acc[src[s]]) sent[s]++;
      if (out_valid[0]) begin
        if (n < 18) chk("rr_order", od(0), exp_q[n]);
        n++;
      end
    end
    in_valid = '0;
    chk("rr_count", n, 18);

    out_ready[2] = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      put(4, 33'(5 | (n << 8)), n < 6);
      acc = in_valid & in_ready;
      tick;
      if (acc[4]) n++;
    end
    chk("full_accepted", n, 5);
    chk("full_in_ready", in_ready[4], 1'b0);
    chk("full_held_valid", out_valid[2], 1'b1);
    put(4, '0, 1'b0);
    out_ready[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", out_valid[2], 1'b1);
      chk("drain_data", od(2), 33'(1 | (k << 8)));
      tick;
    end
    chk("drain_empty", out_valid[2], 1'b0);
    chk("drain_in_ready", in_ready[4], 1'b1);

    out_ready[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      put(0, 33'(32'h10 | (c << 8)), c < 4);
      put(4, 33'(5 | (c << 8)), c < 2);
      if (c < 4) chk("hol_in_ready", in_ready[0], 1'b1);
      tick;
      if (c >= 1 && c <= 4) begin
        chk("hol_n_valid", out_valid[1], 1'b1);
        chk("hol_n_data", od(1), 33'((c - 1) << 8));
      end
      if (c == 5) chk("hol_n_done", out_valid[1], 1'b0);
    end
    chk("hol_e_blocked", out_valid[2], 1'b1);
    put(4, 33'h705, 1'b1);
    tick;
    put(4, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 5'b00000);
    chk("mid_rst_in_ready", in_ready, 5'b00000);
    chk("mid_rst_out_data", out_data, '0);
    out_ready = 5'b11111;
    @(negedge clk) rst_n = 1'b1;
    tick;
    chk("mid_rel_in_ready", in_ready, 5'b11111);
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_stale", out_valid, 5'b00000);
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mesh_router_sync.md
Name: mesh_router_sync

Overview:
- Clocked, parametrised 5-port mesh router node; successor to the fixed-size handshake mesh fabric.
- Ports: Local (PE), N, E, S, W. Each input has a DEPTH-entry FIFO; each output has a one-entry output register.
- Routing is dimension-ordered by hop count (X first, then Y); each output has a round-robin arbiter.
- Tiled into ROW x COL meshes by a generated top, which replaces the hand-wired per-PE hop parameters.

Parameters:
- WIDTH, 33: packet width in bits.
- DEPTH, 4: input FIFO entries per port, power of two, >= 2.
- X_HOP_LOC, 2: LSB of the X hop-count field.
- X_HOP_W, 2: X hop-count field width.
- Y_HOP_LOC, 4: LSB of the Y hop-count field.
- Y_HOP_W, 1: Y hop-count field width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  5  per-port input valid. Index 0=L, 1=N, 2=E, 3=S, 4=W.
- in_ready  out  5  per-port input ready.
- in_data  in  5*WIDTH  input packets; port p occupies [p*WIDTH +: WIDTH].
- out_valid  out  5  per-port output valid.
- out_ready  in  5  per-port downstream ready.
- out_data  out  5*WIDTH  output packets, same packing as in_data.

Behaviour:
- Reset (async assert, sync deassert): all FIFOs empty, out_valid=0, out_data=0, all RR pointers=0. in_ready=0 while rst_n=0, then 1 from the first cycle after release.
- Reset mid-operation: in-flight packets are discarded. No partial transfer completes.
- Handshake: transfer happens on the rising edge where valid&&ready. valid must hold, with stable data, until accepted. in_ready = !fifo_full[p] and does not depend on in_valid.
- Packet header fields:
  - dir[1:0] = data[1:0]. dir[0]=1 means East, else West. dir[1]=1 means South, else North.
  - xh = data[X_HOP_LOC +: X_HOP_W]; yh = data[Y_HOP_LOC +: Y_HOP_W].
- Route of each FIFO head:
  - xh != 0: route to E/W per dir[0]; forwarded copy has xh-1.
  - else yh != 0: route to S/N per dir[1]; forwarded copy has yh-1.
  - else: route to L, packet unmodified.
  - Decrement never wraps because 0 is never decremented. All other bits pass through untouched.
- U-turns and L->L loopback are legal; no filtering.
- Arbitration, per output o:
  - Candidates are inputs whose non-empty head routes to o.
  - Grant goes to the first candidate at or after ptr[o], searching cyclically 0..4.
  - On a grant to input i, ptr[o] becomes (i+1) mod 5.
- Load condition: output register o loads the granted packet when !out_valid[o] || out_ready[o]. This gives full throughput of 1 packet/cycle/output under continuous ready.
- Pop: the granted FIFO pops on the same edge the output register loads. No grant and no pointer update when the load condition is false.
- Each input head requests exactly one output, so no input is ever granted twice in one cycle.
- Latency: packet accepted at edge E0 is valid on out from edge E1, with empty FIFO and free output. Back-pressure on one output never stalls packets at other FIFO heads.
- FIFO boundaries:
  - Simultaneous push and pop when full is impossible, because in_ready=0.
  - Simultaneous push and pop at any other occupancy keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- Starvation-free: with continuous contention, each requester is served within 5 grants of its output.

Test Plan:
- Single hop: reset, then W in_data with dir=01, xh=1, yh=0 (0x00000005) -> E out_data=0x00000001 after 1 cycle. After reset release, in_ready=5'b11111.
- X-then-Y: L injects dir=11, xh=2, yh=1 -> E output with xh=1, yh=1. Feeding that packet back into W routes it to E with xh=0, yh=1. Feeding again routes to S with yh=0. A final arrival goes to L.
- Round-robin fairness: N, S and W each send 6 packets to L with out_ready=1. Grant order is N, S, W, N, S, W, ... starting from ptr=0, and no packet is lost or reordered per source.
- Back-pressure/full: out_ready[E]=0 while W pushes 6 packets (DEPTH=4). in_ready[W] drops after 5 accepted (4 FIFO + 1 output register). On out_ready=1, all 5 drain in order at 1/cycle.
- Head-of-line independence: E output blocked while L sends packets to N. L->N traffic flows at 1/cycle unaffected.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 packets queued -> out_valid=0 immediately. After release, the FIFOs are empty and no stale packet emerges.
